// File: rtl/wb_pkg.sv
// Shared opcode constants, writeback qualification and arbitration types
// for the register-file writeback arbiter.
package wb_pkg;

    localparam logic [3:0] OPC_ADD   = 4'h0;
    localparam logic [3:0] OPC_SUB   = 4'h1;
    localparam logic [3:0] OPC_AND   = 4'h2;
    localparam logic [3:0] OPC_OR    = 4'h3;
    localparam logic [3:0] OPC_XOR   = 4'h4;
    localparam logic [3:0] OPC_SLL   = 4'h5;
    localparam logic [3:0] OPC_SRL   = 4'h6;
    localparam logic [3:0] OPC_SRA   = 4'h7;
    localparam logic [3:0] OPC_BEQ   = 4'h8;
    localparam logic [3:0] OPC_BNE   = 4'h9;
    localparam logic [3:0] OPC_STORE = 4'hA;
    localparam logic [3:0] OPC_LUI   = 4'hB;
    localparam logic [3:0] OPC_JMP   = 4'hC;
    localparam logic [3:0] OPC_NOP   = 4'hD;
    localparam logic [3:0] OPC_FENCE = 4'hE;
    localparam logic [3:0] OPC_HALT  = 4'hF;

    // Bit n set means opcode n produces a register-file write.
    localparam logic [15:0] WB_MASK = 16'b0000_1000_1111_1111;

    function automatic logic is_wb(input logic [3:0] opcode);
        return WB_MASK[opcode];
    endfunction

    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } grant_src_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a writeback source. Flush wins over load,
// load wins over clear so a granted slot can refill in the same cycle.
module wb_slot
    import wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            rd    <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            rd    <= ld_rd;
            data  <= ld_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// result path and the load-return path; write port is driven from flops.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [OPC_W-1:0]  alu_opcode,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [7:0]        drop_cnt,
    output grant_src_t        last_grant
);

    // Handshake: a beat transfers on a rising edge where valid && ready are
    // both high; ready never depends on valid, and valid may not wait on ready.

    grant_src_t        last_grant_nxt;
    logic              alu_slot_v, mem_slot_v;
    logic [ADDR_W-1:0] alu_slot_rd, mem_slot_rd;
    logic [DATA_W-1:0] alu_slot_data, mem_slot_data;
    logic              alu_grant, mem_grant;
    logic              alu_acc, mem_acc, alu_load, alu_drop;

    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (!flush) begin
            if (alu_slot_v && mem_slot_v) begin
                alu_grant = (last_grant == LAST_MEM);
                mem_grant = (last_grant == LAST_ALU);
            end else begin
                alu_grant = alu_slot_v;
                mem_grant = mem_slot_v;
            end
        end
    end

    assign alu_ready = !flush && (!alu_slot_v || alu_grant);
    assign mem_ready = !flush && (!mem_slot_v || mem_grant);
    assign alu_acc   = alu_valid && alu_ready;
    assign mem_acc   = mem_valid && mem_ready;
    assign alu_load  = alu_acc && is_wb(alu_opcode);
    assign alu_drop  = alu_acc && !is_wb(alu_opcode);

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .load    (alu_load),
        .clear   (alu_grant),
        .ld_rd   (alu_rd),
        .ld_data (alu_data),
        .valid   (alu_slot_v),
        .rd      (alu_slot_rd),
        .data    (alu_slot_data)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .load    (mem_acc),
        .clear   (mem_grant),
        .ld_rd   (mem_rd),
        .ld_data (mem_data),
        .valid   (mem_slot_v),
        .rd      (mem_slot_rd),
        .data    (mem_slot_data)
    );

    always_comb begin
        last_grant_nxt = last_grant;
        if (alu_grant) begin
            last_grant_nxt = LAST_ALU;
        end else if (mem_grant) begin
            last_grant_nxt = LAST_MEM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= LAST_MEM;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    // Address and data hold their last value when no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (alu_grant) begin
            rf_we    <= 1'b1;
            rf_waddr <= alu_slot_rd;
            rf_wdata <= alu_slot_data;
        end else if (mem_grant) begin
            rf_we    <= 1'b1;
            rf_waddr <= mem_slot_rd;
            rf_wdata <= mem_slot_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (alu_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sharing the single register-file write port between the ALU result path and the memory-load return path. Each ALU beat is qualified by its 4-bit opcode: only writeback-producing opcodes reach the register file, and all other ALU beats are consumed and counted. Each source has a one-entry holding slot. Contention is resolved round-robin, and the write port is driven from registers. The block sits between execute/memory and the register file, replacing direct opcode-decoded fan-out to the write port.

## Interface
- DATA_W, 16, width of result data
- ADDR_W, 4, destination register index width
- OPC_W, 4, opcode width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of both holding slots
- alu_valid  in  1  ALU beat valid
- alu_ready  out  1  ALU beat accepted when valid && ready
- alu_opcode  in  OPC_W  opcode of ALU beat
- alu_rd  in  ADDR_W  destination register
- alu_data  in  DATA_W  result
- mem_valid  in  1  load-return beat valid
- mem_ready  out  1  load beat accepted when valid && ready
- mem_rd  in  ADDR_W  destination register
- mem_data  in  DATA_W  load data
- rf_we  out  1  register-file write enable, registered
- rf_waddr  out  ADDR_W  write address, registered
- rf_wdata  out  DATA_W  write data, registered
- drop_cnt  out  8  saturating count of non-writeback ALU beats consumed

## Operation
- Writeback opcodes: 0000–0111 and 1011. All others (1000, 1001, 1010, 1100–1111) are non-writeback.
- Holding slots: each source has a slot holding valid, rd and data.
- alu_ready = !flush && (!alu_slot_v || alu_grant). mem_ready follows the same rule using its own slot and grant.
- An accepted ALU beat with a writeback opcode loads the ALU slot.
- An accepted ALU beat with a non-writeback opcode does not load the slot. Instead, drop_cnt increments, saturating at 255.
- Every accepted mem beat loads the mem slot. Mem beats have no opcode.
- Arbitration uses the registered 2-state pointer last_grant (LAST_ALU, LAST_MEM). Reset state is LAST_MEM, so ALU wins the first tie.
  - Only one slot valid: that slot is granted.
  - Both slots valid: the source other than last_grant is granted.
  - No slot valid: no grant; last_grant holds.
- On a grant:
  - the granted slot's rd and data register onto rf_waddr and rf_wdata, with rf_we=1 next cycle;
  - the granted slot clears unless it is refilled the same cycle;
  - last_grant updates to the granted source.
- Without a grant, rf_we=0 next cycle. rf_waddr and rf_wdata hold their last values.
- Same rd in both slots: two separate writes, in arbitration order. No merging or ordering check.
- flush=1: both slots clear, no grant, ready=0, rf_we=0 next cycle. drop_cnt and last_grant are unaffected.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, drop_cnt=0, both slots empty, last_grant=LAST_MEM.
- Ready outputs after reset: alu_ready=1 and mem_ready=1 (unless flush is asserted).
- Latency: a beat accepted at edge N is in its slot after N. When uncontested, rf_we=1 after edge N+1, i.e. 2 cycles from handshake to write.
- Throughput: a lone source sustains one write per cycle, because a slot refills in the cycle it is granted.
- Under continuous contention the sources alternate A,M,A,M. Each stalls at most 1 cycle per write.
- Reset asserted mid-operation: all state clears immediately and asynchronously. In-flight slot contents are lost, and rf_we drops without waiting for a clock.
- drop_cnt at 255 stays 255 on further drops.

## Structure
- Package wb_pkg holds:
  - the OPC_* constants for all 16 opcodes;
  - WB_MASK = 16'b0000_1000_1111_1111, indexed by opcode;
  - function is_wb(opcode);
  - enum grant_src_t {LAST_ALU, LAST_MEM}.
- Sub-module wb_slot: one-entry holding register with load, clear and flush inputs, and valid/rd/data outputs. It is instantiated twice. The arbiter and drop counter live in wb_arbiter.

## Test plan
- Single ALU beat, opcode 0011, rd=5, data=16'h1234 -> rf_we=1, rf_waddr=5, rf_wdata=16'h1234 exactly 2 cycles after handshake; drop_cnt=0.
- ALU beat with opcode 1000, then opcode 1111 -> both accepted, no rf_we, drop_cnt=2. Opcode 1011 with rd=3 -> rf_we=1 with rf_waddr=3.
- ALU and mem valid every cycle for 8 cycles after reset, with distinct rd -> writes alternate ALU,MEM,…, ALU first. Each source is ready every other cycle.
- Lone mem stream of 4 back-to-back beats, rd=1..4 -> 4 consecutive rf_we cycles with waddr 1,2,3,4 and no bubbles.
- Both slots full, then flush pulsed 1 cycle -> no rf_we that cycle or the next; ready=0 during flush; slots empty afterwards.
- 300 non-writeback ALU beats -> drop_cnt saturates at 255. Asserting rst_n=0 mid-stream between edges -> rf_we=0 and drop_cnt=0 immediately.
